// File: rtl/rdma_dp_pkg.sv
// Shared RDMA datapath helpers: lane arithmetic and slot state shared by the
// packet segmenter and reassembler.
package rdma_dp_pkg;

   function automatic int gcd(input int a, input int b);
      int x;
      int y;
      int t;
      x = a;
      y = b;
      while (y != 0) begin
         t = y;
         y = x % y;
         x = t;
      end
      return x;
   endfunction

   function automatic int lcm(input int a, input int b);
      return (a / gcd(a, b)) * b;
   endfunction

   function automatic int lane_count(input int frame_w, input int mtu);
      return frame_w / mtu;
   endfunction

   // Index width that stays legal (>= 1 bit) for a single-lane frame.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_MTU   = 64;
   localparam int DEF_FRAME = 128;
   localparam int DEF_N     = DEF_FRAME / DEF_MTU;

   typedef struct packed {
      logic [DEF_FRAME-1:0] data;
      logic [DEF_N-1:0]     keep;
      logic                 last;
      logic                 full;
   } slot_state_t;

endpackage

// File: rtl/packet_reassembler_if.sv
// Inbound beat stream plus outbound DMA frame stream of the packet reassembler.
interface packet_reassembler_if
   import rdma_dp_pkg::*;
#(
   parameter int MTU            = 64,
   parameter int AXI_FRAME_SIZE = 128
);
   localparam int N = lane_count(AXI_FRAME_SIZE, MTU);

   logic [MTU-1:0]            iPKT_DATA;
   logic                      iVALID;
   logic                      iLAST;
   logic                      oREADY;
   logic [AXI_FRAME_SIZE-1:0] oDMA_DATA;
   logic [N-1:0]              oKEEP;
   logic                      oLAST;
   logic                      oVALID;
   logic                      iREADY;

   modport master (
      output iPKT_DATA, iVALID, iLAST, iREADY,
      input  oREADY, oDMA_DATA, oKEEP, oLAST, oVALID
   );

   modport slave (
      input  iPKT_DATA, iVALID, iLAST, iREADY,
      output oREADY, oDMA_DATA, oKEEP, oLAST, oVALID
   );
endinterface

// File: rtl/reassembly_slot.sv
// One frame slot: lane-addressed write, full/last flags, cleared to zero on drain
// so unwritten lanes of a short frame read back as padding.
module reassembly_slot
   import rdma_dp_pkg::*;
#(
   parameter int MTU            = 64,
   parameter int AXI_FRAME_SIZE = 128,
   localparam int N             = lane_count(AXI_FRAME_SIZE, MTU),
   localparam int LW            = idx_w(N)
) (
   input  logic                      iClk,
   input  logic                      iRst,
   input  logic                      iWr,
   input  logic [LW-1:0]             iLane,
   input  logic [MTU-1:0]            iData,
   input  logic                      iClose,
   input  logic                      iLast,
   input  logic                      iDrain,
   output logic [AXI_FRAME_SIZE-1:0] oData,
   output logic [N-1:0]              oKeep,
   output logic                      oLast,
   output logic                      oFull
);

   logic [AXI_FRAME_SIZE-1:0] data_q, data_d;
   logic [N-1:0]              keep_q, keep_d;
   logic                      last_q, last_d;
   logic                      full_q, full_d;

   always_comb begin
      data_d = data_q;
      keep_d = keep_q;
      last_d = last_q;
      full_d = full_q;
      if (iDrain) begin
         data_d = '0;
         keep_d = '0;
         last_d = 1'b0;
         full_d = 1'b0;
      end
      if (iWr) begin
         data_d[iLane*MTU +: MTU] = iData;
         keep_d[iLane]            = 1'b1;
         if (iClose) begin
            full_d = 1'b1;
            last_d = iLast;
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         data_q <= '0;
         keep_q <= '0;
         last_q <= 1'b0;
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         keep_q <= keep_d;
         last_q <= last_d;
         full_q <= full_d;
      end
   end

   assign oData = data_q;
   assign oKeep = keep_q;
   assign oLast = last_q;
   assign oFull = full_q;

endmodule

// File: rtl/packet_reassembler.sv
// Packs MTU-wide beats into AXI_FRAME_SIZE-wide DMA frames through two ping-pong
// slots and a registered output stage; iLAST closes a frame early.
module packet_reassembler
   import rdma_dp_pkg::*;
#(
   parameter int MTU            = 64,
   parameter int AXI_FRAME_SIZE = 128
) (
   input  logic                  iClk,
   input  logic                  iRst,
   packet_reassembler_if.slave   bus
);

   localparam int N  = lane_count(AXI_FRAME_SIZE, MTU);
   localparam int LW = idx_w(N);

   if (AXI_FRAME_SIZE < MTU || lcm(MTU, AXI_FRAME_SIZE) != AXI_FRAME_SIZE) begin : g_bad_cfg
      $error("packet_reassembler: AXI_FRAME_SIZE must be an integer multiple of MTU");
   end

   logic                      wr_slot_q, wr_slot_d;
   logic                      rd_slot_q, rd_slot_d;
   logic [LW-1:0]             lane_cnt_q, lane_cnt_d;
   logic [AXI_FRAME_SIZE-1:0] dma_data_q, dma_data_d;
   logic [N-1:0]              keep_q, keep_d;
   logic                      last_q, last_d;
   logic                      valid_q, valid_d;

   logic [1:0]                slot_wr;
   logic [1:0]                slot_drain;
   logic [AXI_FRAME_SIZE-1:0] slot_data [2];
   logic [N-1:0]              slot_keep [2];
   logic                      slot_last [2];
   logic                      slot_full [2];

   logic oready;
   logic accept;
   logic close;
   logic out_free;

   // Ready depends only on registered slot state, never on iVALID.
   assign oready   = !slot_full[wr_slot_q];
   assign accept   = bus.iVALID && oready;
   assign close    = accept && ((lane_cnt_q == LW'(N-1)) || bus.iLAST);
   assign out_free = !valid_q || bus.iREADY;

   for (genvar s = 0; s < 2; s++) begin : g_slot
      reassembly_slot #(
         .MTU            (MTU),
         .AXI_FRAME_SIZE (AXI_FRAME_SIZE)
      ) u_slot (
         .iClk   (iClk),
         .iRst   (iRst),
         .iWr    (slot_wr[s]),
         .iLane  (lane_cnt_q),
         .iData  (bus.iPKT_DATA),
         .iClose (close),
         .iLast  (bus.iLAST),
         .iDrain (slot_drain[s]),
         .oData  (slot_data[s]),
         .oKeep  (slot_keep[s]),
         .oLast  (slot_last[s]),
         .oFull  (slot_full[s])
      );
   end

   always_comb begin
      wr_slot_d  = wr_slot_q;
      rd_slot_d  = rd_slot_q;
      lane_cnt_d = lane_cnt_q;
      dma_data_d = dma_data_q;
      keep_d     = keep_q;
      last_d     = last_q;
      valid_d    = valid_q;
      slot_wr    = 2'b00;
      slot_drain = 2'b00;

      if (accept) begin
         slot_wr[wr_slot_q] = 1'b1;
         if (close) begin
            lane_cnt_d = '0;
            wr_slot_d  = !wr_slot_q;
         end else begin
            lane_cnt_d = lane_cnt_q + LW'(1);
         end
      end

      // Drain only looks at registered full flags, so it never hits the slot
      // being written this cycle.
      if (out_free) begin
         if (slot_full[rd_slot_q]) begin
            dma_data_d            = slot_data[rd_slot_q];
            keep_d                = slot_keep[rd_slot_q];
            last_d                = slot_last[rd_slot_q];
            valid_d               = 1'b1;
            slot_drain[rd_slot_q] = 1'b1;
            rd_slot_d             = !rd_slot_q;
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         wr_slot_q  <= 1'b0;
         rd_slot_q  <= 1'b0;
         lane_cnt_q <= '0;
         dma_data_q <= '0;
         keep_q     <= '0;
         last_q     <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         wr_slot_q  <= wr_slot_d;
         rd_slot_q  <= rd_slot_d;
         lane_cnt_q <= lane_cnt_d;
         dma_data_q <= dma_data_d;
         keep_q     <= keep_d;
         last_q     <= last_d;
         valid_q    <= valid_d;
      end
   end

   assign bus.oREADY    = oready;
   assign bus.oDMA_DATA = dma_data_q;
   assign bus.oKEEP     = keep_q;
   assign bus.oLAST     = last_q;
   assign bus.oVALID    = valid_q;

endmodule
